// File: rtl/cmn_age_pkg.sv
// rtl/cmn_age_pkg.sv - shared types and pick helpers for age-ordered buffers
package cmn_age_pkg;

  localparam int MAX_DEPTH = 16;
  localparam int MAX_IDX_W = 4;

  typedef logic [MAX_DEPTH-1:0] vec_t;
  typedef vec_t [MAX_DEPTH-1:0] age_mat_t;

  function automatic logic [MAX_IDX_W-1:0] onehot2idx(vec_t oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  // Isolates the lowest clear bit of busy as a one-hot vector.
  function automatic vec_t lowest_free(vec_t busy);
    vec_t f;
    f = ~busy;
    return f & (~f + vec_t'(1));
  endfunction

  function automatic vec_t oldest_sel(age_mat_t age, vec_t cand);
    vec_t g;
    g = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      g[i] = cand[i] & ~|(age[i] & cand);
    end
    return g;
  endfunction

  // Flat position of stored pair (i,j), i<j, in the upper triangle of an n x n matrix.
  function automatic int pair_idx(int i, int j, int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/cmn_age_oldest_sel.sv
// rtl/cmn_age_oldest_sel.sv - one-hot grant of the oldest candidate from an age matrix
module cmn_age_oldest_sel
  import cmn_age_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0][DEPTH-1:0] age_i,
  input  logic [DEPTH-1:0]            cand_i,
  output logic [DEPTH-1:0]            grant_o
);

  age_mat_t age_pad;
  vec_t     cand_pad;

  always_comb begin
    age_pad  = '0;
    cand_pad = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_pad[i][DEPTH-1:0] = age_i[i];
    end
    cand_pad[DEPTH-1:0] = cand_i;
  end

  assign grant_o = DEPTH'(oldest_sel(age_pad, cand_pad));

endmodule

// File: rtl/cmn_age_issue_buf.sv
// rtl/cmn_age_issue_buf.sv - issue buffer that drains the oldest ready entry each cycle
module cmn_age_issue_buf
  import cmn_age_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_ready_bit,
  input  logic [DEPTH-1:0]  wakeup_vec,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic [IDX_W:0]    count
);

  localparam int NPAIR = DEPTH * (DEPTH - 1) / 2;
  localparam int CW    = IDX_W + 1;

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0]            ready_q, ready_d;
  logic [NPAIR-1:0]            tri_q, tri_d;
  logic [CW-1:0]               count_q, count_d;
  logic [DATA_W-1:0]           payload_q [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] age_full;
  logic [DEPTH-1:0]            cand, grant, alloc_oh, issue_oh;
  logic                        alloc_fire, issue_fire;
  vec_t                        busy_pad;

  // Only the upper triangle is stored; the lower one is its complement.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
      if (gi < gj) begin : g_up
        localparam int P = pair_idx(gi, gj, DEPTH);
        assign age_full[gi][gj] = tri_q[P];
        assign tri_d[P] = alloc_oh[gi] ? 1'b1 : (alloc_oh[gj] ? 1'b0 : tri_q[P]);
      end else if (gi > gj) begin : g_lo
        localparam int P = pair_idx(gj, gi, DEPTH);
        assign age_full[gi][gj] = ~tri_q[P];
      end else begin : g_diag
        assign age_full[gi][gj] = 1'b0;
      end
    end
  end

  assign cand = valid_q & ready_q;

  cmn_age_oldest_sel #(.DEPTH(DEPTH)) u_oldest_sel (
    .age_i   (age_full),
    .cand_i  (cand),
    .grant_o (grant)
  );

  assign in_rdy     = ~&valid_q;
  assign out_vld    = |cand;
  assign out_idx    = IDX_W'(onehot2idx(MAX_DEPTH'(grant)));
  assign count      = count_q;
  assign alloc_fire = in_vld & in_rdy & ~flush;
  assign issue_fire = out_vld & out_rdy & ~flush;
  assign issue_oh   = issue_fire ? grant : '0;

  always_comb begin
    busy_pad             = '1;
    busy_pad[DEPTH-1:0]  = valid_q;
    alloc_oh             = alloc_fire ? DEPTH'(lowest_free(busy_pad)) : '0;
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      out_data = out_data | ({DATA_W{grant[i]}} & payload_q[i]);
    end
  end

  always_comb begin
    valid_d = (valid_q & ~issue_oh) | alloc_oh;
    ready_d = ((ready_q | (wakeup_vec & valid_q)) & ~issue_oh & ~alloc_oh)
            | (alloc_oh & {DEPTH{in_ready_bit}});
    count_d = count_q;
    case ({alloc_fire, issue_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      valid_d = '0;
      ready_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ready_q <= '0;
      tri_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      tri_q   <= tri_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_oh[i]) payload_q[i] <= in_data;
    end
  end

endmodule

// File: doc/cmn_age_issue_buf.md
Name: cmn_age_issue_buf

Overview:
Small out-of-order issue buffer. It accepts one entry per cycle into a free slot and tracks relative entry age in an internal age matrix. Entries become ready at allocation or through a later wakeup. Each cycle it issues the oldest ready entry to a consumer over a valid/ready handshake. It is the drain side of age-ordered allocation, used in front of execution pipes and LSU replay queues.

Parameters:
DEPTH, 4, number of entries (2..16)
DATA_W, 32, payload width
IDX_W, $clog2(DEPTH), entry index width (derived; do not override)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all entries
in_vld  input  1  allocation request
in_rdy  output  1  at least one free entry
in_data  input  DATA_W  allocation payload
in_ready_bit  input  1  entry is ready to issue at allocation
wakeup_vec  input  DEPTH  per-entry ready-set strobes
out_vld  output  1  some valid entry is ready
out_rdy  input  1  consumer accepts
out_data  output  DATA_W  payload of the selected entry
out_idx  output  IDX_W  slot index of the selected entry
count  output  IDX_W+1  number of valid entries

Behaviour:
- Reset is applied to clk and rst_n: asynchronous, active-low. While rst_n is low:
  - valid[] = 0, ready[] = 0, age matrix = 0.
  - Outputs: in_rdy = 1, out_vld = 0, count = 0, out_idx = 0.
  - The payload array is not reset. Drive out_data to 0 when out_vld = 0.
- State per entry: valid, ready, payload. Age matrix: age[i][j] = 1 means i is younger than j. The diagonal is 0. Only i < j bits are stored; age[j][i] = ~age[i][j].
- in_rdy = ~&valid. It is computed from registered state only, so a slot freed by an issue this cycle is not reusable until the next cycle.
- Alloc fires on in_vld & in_rdy:
  - Target slot is the lowest-index free entry.
  - valid <= 1, ready <= in_ready_bit, payload <= in_data.
  - The new slot becomes younger than every other entry: its row bits are set to 1, its column bits to 0.
  - At most one alloc per cycle.
- Wakeup: for each i with wakeup_vec[i] & valid[i], ready[i] <= 1 at the next edge.
  - Wakeup on an invalid slot, including a slot being allocated this cycle, is ignored.
  - Wakeup on an entry that is issuing this cycle is harmless.
- Select: cand = valid & ready.
  - Entry i is oldest when, for all j != i with cand[j], age[i][j] = 0.
  - The resulting grant is one-hot.
  - out_vld = |cand. out_idx and out_data come from the grant. Select is combinational from registers, with zero latency.
- Issue fires on out_vld & out_rdy: valid[out_idx] <= 0 and ready[out_idx] <= 0. Age bits are left stale; they are overwritten on the next alloc of that slot.
- Output stability: out_idx/out_data may change while out_vld is high and out_rdy is low, for example when an older entry wakes up. These are issue-select semantics, not a stable stream.
- Simultaneous alloc + issue: both take effect. count is unchanged. The alloc target never equals the issued slot.
- flush has priority over alloc, wakeup and issue in the same cycle. The next cycle has valid = 0, ready = 0, count = 0, out_vld = 0. Age bits are left as they are.
- count is a registered population of valid, updated +1/-1/0 per cycle, or 0 on flush.
- Reset asserted mid-operation: all state and outputs go to reset values immediately. Any in-flight handshake is lost.

Decomposition:
- Package cmn_age_pkg:
  - function onehot2idx.
  - function lowest_free(vec) returning a one-hot vector.
  - function oldest_sel(age, cand) returning a one-hot vector.
- Sub-module cmn_age_oldest_sel: combinational; inputs are the age matrix and the candidate vector; output is the one-hot grant. Reusable by other pickers.
- Age matrix update and entry arrays stay in cmn_age_issue_buf.

Test Plan (DEPTH = 4):
1. Alloc 0xA, 0xB, 0xC, all ready, out_rdy = 0, then out_rdy = 1 -> out_data A, B, C with out_idx 0, 1, 2 on consecutive cycles; count goes 3 -> 0; out_vld then drops.
2. Alloc A (not ready) then B (ready) -> B issues first at idx1; then wakeup_vec = 4'b0001 -> A issues at idx0 the next cycle.
3. Fill 4 slots, all not ready -> in_rdy = 0, count = 4. Wake idx1 and issue it -> in_rdy = 1 next cycle. Alloc D lands in idx1. Wake all -> issue order idx0, 2, 3, 1.
4. Same cycle: flush with alloc firing, issue firing and wakeup -> next cycle count = 0, out_vld = 0, in_rdy = 1; the alloc is dropped.
5. Three entries valid; assert rst_n low mid-cycle -> out_vld = 0, in_rdy = 1, count = 0 without waiting for a clock edge; after release, the first alloc goes to idx0.
6. Wakeup on the slot being allocated (in_ready_bit = 0) -> entry stays not ready and out_vld = 0. A later wakeup makes out_vld = 1.
